mobo_mem_ctrl: RTL and testbench

Motherboard-side memory controller that consumes the CPU's bus transactions. It takes the `mobo_ctrl` command word, address and write data the CPU drives, and runs a four-phase request/done handshake through a wait-state counter. It performs the read or write on an internal word-addressed RAM and returns status on `mobo_stat` and read data for the CPU's inbound data register. It sits directly downstream of `cpu` and upstream of nothing else; the CPU's `C_STATE_READ`/`C_STATE_WRITE` functions poll it.

---
 rtl/mobo_mem_ctrl.sv | 111 +++++++++++
 tb/tb_mobo_mem_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mobo_mem_ctrl.sv
// mobo_mem_ctrl: motherboard memory controller behind the CPU bus.
// Four-phase req/done handshake with wait states and a word RAM.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module mobo_mem_ctrl #(
  parameter int word_width = `WORD_WIDTH,
  parameter int addr_bits  = 8,
  parameter int mem_lat    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] mobo_ctrl,
  output logic [word_width-1:0] mobo_stat,
  input  logic [word_width-1:0] addr_in,
  input  logic [word_width-1:0] cpu_dat_in,
  output logic [word_width-1:0] cpu_dat_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam int depth = 1 << addr_bits;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [word_width-1:0] addr_q;
  logic [word_width-1:0] dat_q;
  logic                  we_q;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [word_width-1:0] rd_q;
  logic [word_width-1:0] mem [depth];

  logic                  req;
  logic                  we;
  logic                  in_range;
  logic [addr_bits-1:0]  idx;
  logic                  ctrl_unused;

  assign req         = mobo_ctrl[0];
  assign we          = mobo_ctrl[1];
  assign ctrl_unused = ^mobo_ctrl[word_width-1:2];
  // range check spans the whole word; only the low bits index the RAM
  assign in_range    = (addr_q >> addr_bits) == '0;
  assign idx         = addr_q[addr_bits-1:0];

  assign mobo_stat   = {{(word_width-3){1'b0}}, err, done, busy};
  assign cpu_dat_out = rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      rd_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            addr_q <= addr_in;
            dat_q  <= cpu_dat_in;
            we_q   <= we;
            busy   <= 1'b1;
            if (mem_lat > 0) begin
              cnt   <= 4'(mem_lat - 1);
              state <= S_WAIT;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_ACCESS;
          else           cnt   <= cnt - 4'd1;
        end
        S_ACCESS: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
          if (!in_range) begin
            err  <= 1'b1;
            rd_q <= '0;
          end else if (!we_q) begin
            rd_q <= mem[idx];
          end
        end
        S_DONE: begin
          if (!req) begin
            done  <= 1'b0;
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM is never cleared; a reset on the access edge drops the write
  always_ff @(posedge clk) begin
    if (!rst && state == S_ACCESS && we_q && in_range)
      mem[idx] <= dat_q;
  end

endmodule

// File: tb/tb_mobo_mem_ctrl.sv
// tb_mobo_mem_ctrl: directed vectors for mobo_mem_ctrl.
// One instance with mem_lat=2 and one with mem_lat=0.
module tb_mobo_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ctrl_a, stat_a, addr_a, din_a, dout_a;
  logic [15:0] ctrl_b, stat_b, addr_b, din_b, dout_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mobo_mem_ctrl #(
    .word_width(16), .addr_bits(4), .mem_lat(2)
  ) dut_a (
    .clk(clk), .rst(rst),
    .mobo_ctrl(ctrl_a), .mobo_stat(stat_a),
    .addr_in(addr_a), .cpu_dat_in(din_a),
    .cpu_dat_out(dout_a)
  );

  mobo_mem_ctrl #(
    .word_width(16), .addr_bits(4), .mem_lat(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .mobo_ctrl(ctrl_b), .mobo_stat(stat_b),
    .addr_in(addr_b), .cpu_dat_in(din_b),
    .cpu_dat_out(dout_b)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic        err;
    logic [15:0] dout;
  } vec_t;

  localparam int NV = 12;
  vec_t v [NV];

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Issue on A, wait for done; leaves req high at a negedge.
  task automatic a_start(input logic we,
                         input logic [15:0] addr,
                         input logic [15:0] data,
                         input logic churn);
    int cyc;
    @(negedge clk);
    ctrl_a = {14'b0, we, 1'b1};
    addr_a = addr;
    din_a  = data;
    @(posedge clk);
    @(negedge clk);
    chk("a_busy", stat_a, 16'h0001);
    if (churn) begin
      addr_a = 16'h0006;
      din_a  = 16'h9999;
    end
    cyc = 0;
    while (stat_a[1] !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (churn) begin
        addr_a = 16'h0003;
        din_a  = 16'hAAAA;
      end
    end
    chk("a_latency", 16'(cyc), 16'd3);
  endtask

  task automatic a_release();
    ctrl_a = 16'h0;
    @(posedge clk);
    @(negedge clk);
    chk("a_release", stat_a, 16'h0000);
  endtask

  task automatic a_read(input logic [15:0] addr,
                        input logic [15:0] exp);
    a_start(1'b0, addr, 16'h0, 1'b0);
    chk("a_rd_stat", stat_a, 16'h0002);
    chk("a_rd_dout", dout_a, exp);
    a_release();
  endtask

  // Called at a negedge; one accept every 3 cycles on B.
  task automatic b_txn(input logic we,
                       input logic [15:0] addr,
                       input logic [15:0] data,
                       input logic [15:0] exp_stat,
                       input logic [15:0] exp_dout);
    ctrl_b = {14'b0, we, 1'b1};
    addr_b = addr;
    din_b  = data;
    @(posedge clk);
    @(negedge clk);
    chk("b_busy", stat_b, 16'h0001);
    @(posedge clk);
    @(negedge clk);
    chk("b_done", stat_b, exp_stat);
    chk("b_dout", dout_b, exp_dout);
    ctrl_b = 16'h0;
    @(posedge clk);
    @(negedge clk);
    chk("b_idle", stat_b, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    v[0]  = '{1'b1, 16'h0003, 16'h00AB, 1'b0, 16'h0000};
    v[1]  = '{1'b0, 16'h0003, 16'h0000, 1'b0, 16'h00AB};
    v[2]  = '{1'b1, 16'h0000, 16'h1111, 1'b0, 16'h00AB};
    v[3]  = '{1'b1, 16'h0006, 16'h0666, 1'b0, 16'h00AB};
    v[4]  = '{1'b1, 16'h0002, 16'h0001, 1'b0, 16'h00AB};
    v[5]  = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0000};
    v[6]  = '{1'b1, 16'h0010, 16'h1234, 1'b1, 16'h0000};
    v[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1111};
    v[8]  = '{1'b1, 16'h000F, 16'hBEEF, 1'b0, 16'h1111};
    v[9]  = '{1'b0, 16'h000F, 16'h0000, 1'b0, 16'hBEEF};
    v[10] = '{1'b0, 16'h8003, 16'h0000, 1'b1, 16'h0000};
    v[11] = '{1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0001};

    rst    = 1'b1;
    ctrl_a = 16'h0; addr_a = 16'h0; din_a = 16'h0;
    ctrl_b = 16'h0; addr_b = 16'h0; din_b = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stat_a", stat_a, 16'h0000);
    chk("rst_dout_a", dout_a, 16'h0000);
    chk("rst_stat_b", stat_b, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      a_start(v[i].we, v[i].addr, v[i].data, 1'b0);
      chk("vec_stat", stat_a, {13'b0, v[i].err, 2'b10});
      chk("vec_dout", dout_a, v[i].dout);
      a_release();
    end

    // hold req high in DONE
    a_start(1'b0, 16'h0003, 16'h0, 1'b0);
    chk("hold_dout0", dout_a, 16'h00AB);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_stat", stat_a, 16'h0002);
      chk("hold_dout", dout_a, 16'h00AB);
    end
    a_release();

    // churn addr/data during WAIT
    a_start(1'b1, 16'h0005, 16'h0055, 1'b1);
    chk("churn_stat", stat_a, 16'h0002);
    a_release();
    a_read(16'h0005, 16'h0055);
    a_read(16'h0006, 16'h0666);
    a_read(16'h0003, 16'h00AB);

    // reset on the ACCESS edge of a write
    @(negedge clk);
    ctrl_a = 16'h0003;
    addr_a = 16'h0002;
    din_a  = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_stat", stat_a, 16'h0000);
    chk("midrst_dout", dout_a, 16'h0000);
    rst    = 1'b0;
    ctrl_a = 16'h0;
    a_read(16'h0002, 16'h0001);

    // zero latency, back-to-back
    @(negedge clk);
    b_txn(1'b1, 16'h0003, 16'h0033, 16'h0002, 16'h0000);
    b_txn(1'b0, 16'h0003, 16'h0000, 16'h0002, 16'h0033);
    b_txn(1'b1, 16'h0007, 16'h7777, 16'h0002, 16'h0033);
    b_txn(1'b0, 16'h0007, 16'h0000, 16'h0002, 16'h7777);
    b_txn(1'b0, 16'h0020, 16'h0000, 16'h0006, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
